// File: rtl/param_data_memory.sv
// Byte-addressable data memory for the MEM stage of an RV32IM pipeline.
// Every access costs a fixed number of cycles, and busywait stalls the CPU
// during that time. Misaligned, out-of-range and conflicting requests are
// rejected with mem_error instead of being performed.
//
// Handshake: Read/Write are level requests that the CPU holds until it sees
// busywait low. busywait is high in IDLE while a request is present and stays
// high through BUSY. It drops for the single DONE cycle. The CPU advances on
// the edge that closes DONE, and requests seen in DONE are ignored.
module param_data_memory #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic [2:0]  Func3,
  output logic [31:0] Read_data,
  output logic        busywait,
  output logic        mem_error,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    func3_q, func3_d;
  logic          is_write_q, is_write_d;
  logic [31:0]   read_data_q, read_data_d;
  logic          mem_error_q, mem_error_d;
  logic [7:0]    mem_q [DEPTH_BYTES];
  logic [7:0]    mem_d [DEPTH_BYTES];

  logic          req;
  logic          in_range;
  logic          func3_ok;
  logic          aligned;
  logic          req_valid;
  logic          commit;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   load_val;

  // Classify the request currently presented by the CPU.
  always_comb begin
    req      = Read | Write;
    in_range = (Address[31:AW] == '0);
    if (Write) begin
      func3_ok = (Func3 == 3'b000) || (Func3 == 3'b001) || (Func3 == 3'b010);
    end else begin
      func3_ok = (Func3 == 3'b000) || (Func3 == 3'b001) || (Func3 == 3'b010) ||
                 (Func3 == 3'b100) || (Func3 == 3'b101);
    end
    case (Func3[1:0])
      2'b01:   aligned = ~Address[0];
      2'b10:   aligned = (Address[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    req_valid = ~(Read & Write) & in_range & func3_ok & aligned;
  end

  // Byte lanes of the latched access; alignment guarantees they stay in range.
  always_comb begin
    idx0 = addr_q;
    idx1 = addr_q | AW'(1);
    idx2 = addr_q | AW'(2);
    idx3 = addr_q | AW'(3);
    b0   = mem_q[idx0];
    b1   = mem_q[idx1];
    b2   = mem_q[idx2];
    b3   = mem_q[idx3];
    case (func3_q)
      3'b000:  load_val = {{24{b0[7]}}, b0};
      3'b001:  load_val = {{16{b1[7]}}, b1, b0};
      3'b010:  load_val = {b3, b2, b1, b0};
      3'b100:  load_val = {24'd0, b0};
      3'b101:  load_val = {16'd0, b1, b0};
      default: load_val = read_data_q;
    endcase
  end

  // Access sequencing: latch in IDLE, count down in BUSY, report in DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    func3_d     = func3_q;
    is_write_d  = is_write_q;
    mem_error_d = mem_error_q;
    busywait    = 1'b0;
    commit      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busywait = req;
        if (req) begin
          addr_d     = Address[AW-1:0];
          wdata_d    = Write_data;
          func3_d    = Func3;
          is_write_d = Write;
          if (req_valid) begin
            state_d     = S_BUSY;
            cnt_d       = CW'(LATENCY - 1);
            mem_error_d = 1'b0;
          end else begin
            state_d     = S_DONE;
            mem_error_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        busywait = 1'b1;
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        mem_error_d = 1'b0;
      end
      default: begin
        state_d     = S_IDLE;
        mem_error_d = 1'b0;
      end
    endcase
  end

  // Commit the latched store into the addressed bytes, or capture a load.
  always_comb begin
    mem_d       = mem_q;
    read_data_d = read_data_q;
    if (commit) begin
      if (is_write_q) begin
        mem_d[idx0] = wdata_q[7:0];
        if (func3_q[1:0] != 2'b00) begin
          mem_d[idx1] = wdata_q[15:8];
        end
        if (func3_q[1:0] == 2'b10) begin
          mem_d[idx2] = wdata_q[23:16];
          mem_d[idx3] = wdata_q[31:24];
        end
      end else begin
        read_data_d = load_val;
      end
    end
  end

  // Control and datapath registers; reset aborts any access in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      func3_q     <= '0;
      is_write_q  <= 1'b0;
      read_data_q <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      func3_q     <= func3_d;
      is_write_q  <= is_write_d;
      read_data_q <= read_data_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Storage array; cleared by reset so a discarded store leaves no trace.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign Read_data = read_data_q;
  assign mem_error = mem_error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_param_data_memory.sv
// Bench for param_data_memory: a LATENCY=3 instance exercised with directed
// and random traffic against a byte-array reference model, plus a LATENCY=1
// instance for the short-latency and held-request behaviour.
module tb_param_data_memory;

  logic clk;
  int   n_checks;
  int   n_fail;

  // Instance A (LATENCY = 3)
  logic        a_rst_n, a_read, a_write;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [2:0]  a_func3;
  logic        a_busywait, a_mem_error;
  logic [1:0]  a_dbg;

  // Instance B (LATENCY = 1)
  logic        b_rst_n, b_read, b_write;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [2:0]  b_func3;
  logic        b_busywait, b_mem_error;
  logic [1:0]  b_dbg;

  // Reference model of instance A
  logic [7:0]  mem_a [1024];
  logic [31:0] rd_a;

  param_data_memory #(.DEPTH_BYTES(1024), .LATENCY(3)) dut_a (
    .Clock(clk), .Reset(a_rst_n), .Read(a_read), .Write(a_write),
    .Address(a_addr), .Write_data(a_wdata), .Func3(a_func3),
    .Read_data(a_rdata), .busywait(a_busywait), .mem_error(a_mem_error),
    .dbg_state(a_dbg)
  );

  param_data_memory #(.DEPTH_BYTES(1024), .LATENCY(1)) dut_b (
    .Clock(clk), .Reset(b_rst_n), .Read(b_read), .Write(b_write),
    .Address(b_addr), .Write_data(b_wdata), .Func3(b_func3),
    .Read_data(b_rdata), .busywait(b_busywait), .mem_error(b_mem_error),
    .dbg_state(b_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: apply one request using the memory's rules directly.
  task automatic model_a(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] f3, output logic err);
    int n;
    bit sgn;
    int base;
    logic [31:0] v;
    err = 1'b0;
    n   = 1;
    sgn = 1'b0;
    case (f3)
      3'b000: begin n = 1; sgn = 1'b1; end
      3'b001: begin n = 2; sgn = 1'b1; end
      3'b010: n = 4;
      3'b100: begin n = 1; if (wr) err = 1'b1; end
      3'b101: begin n = 2; if (wr) err = 1'b1; end
      default: err = 1'b1;
    endcase
    if (rd && wr) err = 1'b1;
    if (addr >= 32'd1024) err = 1'b1;
    if ((addr % 32'(n)) != 32'd0) err = 1'b1;
    if (!err) begin
      base = int'(addr);
      if (wr) begin
        for (int i = 0; i < n; i++) mem_a[base + i] = data[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_a[base + i];
        if (sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd_a = v;
      end
    end
  endtask

  task automatic model_reset_a();
    for (int i = 0; i < 1024; i++) mem_a[i] = 8'h00;
    rd_a = 32'd0;
  endtask

  // Driver for instance A: present a request, optionally disturb inputs during
  // BUSY, count busywait-high cycles and capture mem_error in DONE.
  task automatic access_a(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] f3,
                          input bit scramble, input bit drop,
                          output int busy, output logic err, output bit tmo);
    @(posedge clk); #1;
    a_read = rd; a_write = wr; a_addr = addr; a_wdata = data; a_func3 = f3;
    busy = 0; err = 1'b0; tmo = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (a_busywait) begin
        busy++;
        if (busy == 2) begin
          if (scramble) begin
            a_addr  = $urandom;
            a_wdata = $urandom;
            a_func3 = 3'($urandom_range(0, 7));
          end
          if (drop) begin
            a_read  = 1'b0;
            a_write = 1'b0;
          end
        end
      end else begin
        err = a_mem_error;
        tmo = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    a_read = 1'b0; a_write = 1'b0;
  endtask

  // Driver for instance B; the request stays high through DONE.
  task automatic access_b(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] f3,
                          output int busy, output logic err, output bit tmo);
    @(posedge clk); #1;
    b_read = rd; b_write = wr; b_addr = addr; b_wdata = data; b_func3 = f3;
    busy = 0; err = 1'b0; tmo = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (b_busywait) begin
        busy++;
      end else begin
        err = b_mem_error;
        tmo = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    b_read = 1'b0; b_write = 1'b0;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_read = 0; a_write = 0; a_addr = 0; a_wdata = 0; a_func3 = 0;
    b_read = 0; b_write = 0; b_addr = 0; b_wdata = 0; b_func3 = 0;
    model_reset_a();
    @(negedge clk);
    n_checks++;
    if (a_busywait !== 1'b0) begin n_fail++; $display("FAIL reset_busywait_a: got %b want 0", a_busywait); end
    n_checks++;
    if (a_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata_a: got %h want 0", a_rdata); end
    n_checks++;
    if (a_mem_error !== 1'b0) begin n_fail++; $display("FAIL reset_err_a: got %b want 0", a_mem_error); end
    n_checks++;
    if (b_rdata !== 32'd0 || b_busywait !== 1'b0 || b_mem_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_b: got rd=%h bw=%b err=%b want 0/0/0", b_rdata, b_busywait, b_mem_error);
    end
    a_read = 1'b1;
    #1;
    n_checks++;
    if (a_busywait !== 1'b1) begin n_fail++; $display("FAIL reset_busywait_follows_req: got %b want 1", a_busywait); end
    a_read = 1'b0;
    @(posedge clk); #1;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic        exp_err;
    logic [31:0] exp_rd;
  } op_t;

  // Directed word/byte/halfword traffic and reject cases with literal results.
  task automatic test_directed();
    op_t ops[18];
    int busy;
    logic err, merr;
    bit tmo;
    ops[0]  = '{1'b0, 1'b1, 32'h4,   32'h1234_5678, 3'b010, 1'b0, 32'h0000_0000};
    ops[1]  = '{1'b1, 1'b0, 32'h4,   32'h0,         3'b010, 1'b0, 32'h1234_5678};
    ops[2]  = '{1'b0, 1'b1, 32'h5,   32'h0000_00AA, 3'b000, 1'b0, 32'h1234_5678};
    ops[3]  = '{1'b1, 1'b0, 32'h5,   32'h0,         3'b000, 1'b0, 32'hFFFF_FFAA};
    ops[4]  = '{1'b1, 1'b0, 32'h5,   32'h0,         3'b100, 1'b0, 32'h0000_00AA};
    ops[5]  = '{1'b1, 1'b0, 32'h4,   32'h0,         3'b010, 1'b0, 32'h1234_AA78};
    ops[6]  = '{1'b0, 1'b1, 32'h6,   32'h0000_BBBB, 3'b001, 1'b0, 32'h1234_AA78};
    ops[7]  = '{1'b1, 1'b0, 32'h6,   32'h0,         3'b001, 1'b0, 32'hFFFF_BBBB};
    ops[8]  = '{1'b1, 1'b0, 32'h6,   32'h0,         3'b101, 1'b0, 32'h0000_BBBB};
    ops[9]  = '{1'b1, 1'b0, 32'h4,   32'h0,         3'b010, 1'b0, 32'hBBBB_AA78};
    ops[10] = '{1'b1, 1'b0, 32'h2,   32'h0,         3'b010, 1'b1, 32'hBBBB_AA78};
    ops[11] = '{1'b0, 1'b1, 32'h7,   32'h0000_1111, 3'b001, 1'b1, 32'hBBBB_AA78};
    ops[12] = '{1'b1, 1'b0, 32'h400, 32'h0,         3'b010, 1'b1, 32'hBBBB_AA78};
    ops[13] = '{1'b1, 1'b1, 32'h4,   32'h5555_5555, 3'b010, 1'b1, 32'hBBBB_AA78};
    ops[14] = '{1'b0, 1'b1, 32'h8,   32'h0000_7777, 3'b101, 1'b1, 32'hBBBB_AA78};
    ops[15] = '{1'b1, 1'b0, 32'h8,   32'h0,         3'b011, 1'b1, 32'hBBBB_AA78};
    ops[16] = '{1'b1, 1'b0, 32'h4,   32'h0,         3'b010, 1'b0, 32'hBBBB_AA78};
    ops[17] = '{1'b1, 1'b0, 32'h8,   32'h0,         3'b010, 1'b0, 32'h0000_0000};
    for (int i = 0; i < 18; i++) begin
      model_a(ops[i].rd, ops[i].wr, ops[i].addr, ops[i].data, ops[i].f3, merr);
      access_a(ops[i].rd, ops[i].wr, ops[i].addr, ops[i].data, ops[i].f3, 1'b0, 1'b0, busy, err, tmo);
      n_checks++;
      if (tmo) begin
        n_fail++; $display("FAIL directed_%0d_timeout: busywait never dropped within 40 cycles", i);
      end
      n_checks++;
      if (busy !== (ops[i].exp_err ? 1 : 4)) begin
        n_fail++; $display("FAIL directed_%0d_busy_cycles: got %0d want %0d", i, busy, ops[i].exp_err ? 1 : 4);
      end
      n_checks++;
      if (err !== ops[i].exp_err || merr !== ops[i].exp_err) begin
        n_fail++; $display("FAIL directed_%0d_mem_error: got %b want %b", i, err, ops[i].exp_err);
      end
      n_checks++;
      if (a_rdata !== ops[i].exp_rd || a_rdata !== rd_a) begin
        n_fail++; $display("FAIL directed_%0d_read_data: got %h want %h", i, a_rdata, ops[i].exp_rd);
      end
    end
  endtask

  // Random traffic with input disturbance and early request drop during BUSY.
  task automatic test_random();
    logic rd, wr, merr, err;
    logic [31:0] addr, data;
    logic [2:0] f3;
    int kind, busy;
    bit tmo, scr, drp;
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      rd   = (kind <= 4) || (kind == 9);
      wr   = (kind >= 5);
      addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1024, 4095)) : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      if ($urandom_range(0, 4) != 0) begin
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      data = $urandom;
      scr  = 1'($urandom_range(0, 1));
      drp  = ($urandom_range(0, 3) == 0);
      model_a(rd, wr, addr, data, f3, merr);
      access_a(rd, wr, addr, data, f3, scr, drp, busy, err, tmo);
      n_checks++;
      if (tmo || busy !== (merr ? 1 : 4)) begin
        n_fail++; $display("FAIL random_%0d_busy_cycles: got %0d (timeout=%0d) want %0d", i, busy, tmo, merr ? 1 : 4);
      end
      n_checks++;
      if (err !== merr) begin
        n_fail++; $display("FAIL random_%0d_mem_error: got %b want %b (rd=%b wr=%b addr=%h f3=%0d)", i, err, merr, rd, wr, addr, f3);
      end
      n_checks++;
      if (a_rdata !== rd_a) begin
        n_fail++; $display("FAIL random_%0d_read_data: got %h want %h (addr=%h f3=%0d)", i, a_rdata, rd_a, addr, f3);
      end
    end
  endtask

  // Reset pulsed in the second BUSY cycle of a store discards everything.
  task automatic test_reset_mid();
    int busy;
    logic err, merr;
    bit tmo;
    model_a(1'b0, 1'b1, 32'h20, 32'h8765_4321, 3'b010, merr);
    access_a(1'b0, 1'b1, 32'h20, 32'h8765_4321, 3'b010, 1'b0, 1'b0, busy, err, tmo);
    model_a(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, merr);
    access_a(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0, 1'b0, busy, err, tmo);
    n_checks++;
    if (a_rdata !== 32'h8765_4321) begin n_fail++; $display("FAIL pre_reset_load: got %h want 87654321", a_rdata); end
    @(posedge clk); #1;
    a_write = 1'b1; a_addr = 32'h10; a_wdata = 32'hDEAD_BEEF; a_func3 = 3'b010;
    @(posedge clk);
    @(posedge clk); #1;
    n_checks++;
    if (a_busywait !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before_reset: got %b want 1", a_busywait); end
    a_rst_n = 1'b0;
    a_write = 1'b0;
    #1;
    n_checks++;
    if (a_busywait !== 1'b0) begin n_fail++; $display("FAIL mid_reset_idle: busywait got %b want 0", a_busywait); end
    n_checks++;
    if (a_rdata !== 32'd0 || a_mem_error !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs: rd got %h err got %b want 0/0", a_rdata, a_mem_error);
    end
    model_reset_a();
    @(posedge clk); @(posedge clk); #1;
    a_rst_n = 1'b1;
    model_a(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, merr);
    access_a(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 1'b0, busy, err, tmo);
    n_checks++;
    if (tmo || busy !== 4 || err !== 1'b0 || a_rdata !== 32'd0) begin
      n_fail++; $display("FAIL after_reset_lw_10: got rd=%h busy=%0d err=%b want 0/4/0", a_rdata, busy, err);
    end
    model_a(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, merr);
    access_a(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0, 1'b0, busy, err, tmo);
    n_checks++;
    if (a_rdata !== rd_a) begin n_fail++; $display("FAIL after_reset_wiped: got %h want %h", a_rdata, rd_a); end
  endtask

  // LATENCY=1 instance: two-cycle accesses and no restart from a held request.
  task automatic test_latency1();
    int busy;
    logic err;
    bit tmo;
    access_b(1'b0, 1'b1, 32'h8, 32'hCAFE_F00D, 3'b010, busy, err, tmo);
    n_checks++;
    if (tmo || busy !== 2 || err !== 1'b0) begin
      n_fail++; $display("FAIL lat1_store: busy got %0d err got %b want 2/0", busy, err);
    end
    access_b(1'b1, 1'b0, 32'h8, 32'h0, 3'b010, busy, err, tmo);
    n_checks++;
    if (tmo || busy !== 2 || err !== 1'b0) begin
      n_fail++; $display("FAIL lat1_load_busy: busy got %0d err got %b want 2/0", busy, err);
    end
    n_checks++;
    if (b_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lat1_load_data: got %h want cafef00d", b_rdata); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (b_busywait !== 1'b0) begin
        n_fail++; $display("FAIL lat1_no_second_access_c%0d: busywait got %b want 0", c, b_busywait);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_latency1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
